w0rm_core_reg_write_arbiter: RTL and testbench

Shares the single register-file write port between the two writeback sources, the ALU and the memory (load) unit. Each source hands off writebacks through a valid/ready handshake into a one-entry holding slot. The block arbitrates between occupied slots and drives a registered write port into the register file. It also exports a pending-write mask that the decode/register-fetch stage uses to stall on RAW hazards.

---
 rtl/w0rm_core_reg_write_arbiter_pkg.sv | 35 +++
 rtl/w0rm_core_wb_slot.sv | 73 +++++++
 rtl/w0rm_core_reg_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_w0rm_core_reg_write_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_core_reg_write_arbiter_pkg.sv
// Shared writeback types, source indices and register-address width helper.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package w0rm_core_reg_write_arbiter_pkg;

   // Source indices used by the round-robin pointer
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // Default core configuration
   localparam int WB_DATA_WIDTH    = 32;
   localparam int WB_NUM_REGISTERS = 16;

   // Smallest address width that can name n registers (at least one bit)
   function automatic int log2_ceil(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   localparam int WB_REG_ADDR_BITS = log2_ceil(WB_NUM_REGISTERS);

   // One writeback entry at the default core configuration
   typedef struct packed {
      logic                        valid;
      logic [WB_REG_ADDR_BITS-1:0] addr;
      logic [WB_DATA_WIDTH-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/w0rm_core_wb_slot.sv
// One-entry writeback holding slot with an age bit for oldest-first arbitration.
// Latency: an accepted entry is visible on the slot outputs one cycle after the transfer edge.
// Backpressure: in_ready = ~valid | grant, so ready never depends on in_valid.
module w0rm_core_wb_slot
   import w0rm_core_reg_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_BITS  = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [ADDR_BITS-1:0]  in_addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  grant,
   input  logic                  other_load,
   input  logic                  other_grant,
   output logic                  load,
   output logic                  valid,
   output logic [ADDR_BITS-1:0]  addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  age
);

   logic                  valid_q, valid_d;
   logic [ADDR_BITS-1:0]  addr_q,  addr_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  age_q,   age_d;

   assign in_ready = ~valid_q | grant;
   assign load     = in_valid & in_ready;

   assign valid = valid_q;
   assign addr  = addr_q;
   assign data  = data_q;
   assign age   = age_q;

   // Load, drain or age the held entry; an entry that outlives activity in the other slot becomes old
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      age_d   = age_q;
      if (load) begin
         valid_d = 1'b1;
         addr_d  = in_addr;
         data_d  = in_data;
         age_d   = 1'b0;
      end else if (grant) begin
         valid_d = 1'b0;
         age_d   = 1'b0;
      end else if (valid_q && (other_load || other_grant)) begin
         age_d   = 1'b1;
      end
   end

   // Slot state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         age_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         age_q   <= age_d;
      end
   end

endmodule

// File: rtl/w0rm_core_reg_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single registered register-file write port.
// Latency: accept at edge N, port_write_enable high after N+1, register file writes at N+2.
// Backpressure: per-source ready from slot state only; a losing source stalls exactly one cycle.
// Optional: define W0RM_RWARB_RR_EN for round-robin equal-age tie-break (default: memory wins ties).
module w0rm_core_reg_write_arbiter
   import w0rm_core_reg_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 16,
   localparam int REG_ADDR_BITS = log2_ceil(NUM_REGISTERS)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     alu_wb_valid,
   input  logic [REG_ADDR_BITS-1:0] alu_wb_addr,
   input  logic [DATA_WIDTH-1:0]    alu_wb_data,
   output logic                     alu_wb_ready,
   input  logic                     mem_wb_valid,
   input  logic [REG_ADDR_BITS-1:0] mem_wb_addr,
   input  logic [DATA_WIDTH-1:0]    mem_wb_data,
   output logic                     mem_wb_ready,
   output logic                     port_write_enable,
   output logic [REG_ADDR_BITS-1:0] port_write_addr,
   output logic [DATA_WIDTH-1:0]    port_write_data,
   output logic [NUM_REGISTERS-1:0] wb_pending_mask
);

   logic                     alu_load, mem_load;
   logic                     alu_vld,  mem_vld;
   logic [REG_ADDR_BITS-1:0] alu_addr, mem_addr;
   logic [DATA_WIDTH-1:0]    alu_dat,  mem_dat;
   logic                     alu_age,  mem_age;
   logic                     grant_alu, grant_mem;

   logic                     out_vld_q,  out_vld_d;
   logic [REG_ADDR_BITS-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;

   w0rm_core_wb_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (REG_ADDR_BITS)
   ) u_alu_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (alu_wb_valid),
      .in_addr     (alu_wb_addr),
      .in_data     (alu_wb_data),
      .in_ready    (alu_wb_ready),
      .grant       (grant_alu),
      .other_load  (mem_load),
      .other_grant (grant_mem),
      .load        (alu_load),
      .valid       (alu_vld),
      .addr        (alu_addr),
      .data        (alu_dat),
      .age         (alu_age)
   );

   w0rm_core_wb_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (REG_ADDR_BITS)
   ) u_mem_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (mem_wb_valid),
      .in_addr     (mem_wb_addr),
      .in_data     (mem_wb_data),
      .in_ready    (mem_wb_ready),
      .grant       (grant_mem),
      .other_load  (alu_load),
      .other_grant (grant_alu),
      .load        (mem_load),
      .valid       (mem_vld),
      .addr        (mem_addr),
      .data        (mem_dat),
      .age         (mem_age)
   );

`ifdef W0RM_RWARB_RR_EN
   logic rr_ptr_q, rr_ptr_d;
   logic tie;

   assign tie = alu_vld & mem_vld & (alu_age == mem_age);

   // Hand the next equal-age tie to the source that did not win this one
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (tie) begin
         rr_ptr_d = ~rr_ptr_q;
      end
   end

   // Round-robin pointer register, favours memory out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q <= SRC_MEM;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Oldest occupied slot wins; equal ages fall to the tie-break
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (alu_vld && mem_vld) begin
         if (alu_age != mem_age) begin
            grant_alu = alu_age;
            grant_mem = mem_age;
         end else begin
`ifdef W0RM_RWARB_RR_EN
            grant_alu = (rr_ptr_q == SRC_ALU);
            grant_mem = (rr_ptr_q == SRC_MEM);
`else
            grant_mem = 1'b1;
`endif
         end
      end else begin
         grant_alu = alu_vld;
         grant_mem = mem_vld;
      end
   end

   // Output stage captures the winner; address and data hold when idle
   always_comb begin
      out_vld_d  = grant_alu | grant_mem;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      if (grant_alu) begin
         out_addr_d = alu_addr;
         out_data_d = alu_dat;
      end else if (grant_mem) begin
         out_addr_d = mem_addr;
         out_data_d = mem_dat;
      end
   end

   // Registered register-file write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_vld_q  <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
      end
   end

   assign port_write_enable = out_vld_q;
   assign port_write_addr   = out_addr_q;
   assign port_write_data   = out_data_q;

   // Pending-write mask: every register named by a held or in-flight write
   always_comb begin
      wb_pending_mask = '0;
      for (int r = 0; r < NUM_REGISTERS; r++) begin
         if ((alu_vld   && (alu_addr   == REG_ADDR_BITS'(r))) ||
             (mem_vld   && (mem_addr   == REG_ADDR_BITS'(r))) ||
             (out_vld_q && (out_addr_q == REG_ADDR_BITS'(r)))) begin
            wb_pending_mask[r] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_w0rm_core_reg_write_arbiter.sv
// Directed bench for the register-file write arbiter.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: sources only offer directed vectors; readies are checked, not obeyed blindly.
module tb_w0rm_core_reg_write_arbiter;

`ifdef W0RM_RWARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        alu_wb_valid, mem_wb_valid;
   logic [3:0]  alu_wb_addr,  mem_wb_addr;
   logic [31:0] alu_wb_data,  mem_wb_data;
   logic        alu_wb_ready, mem_wb_ready;
   logic        port_write_enable;
   logic [3:0]  port_write_addr;
   logic [31:0] port_write_data;
   logic [15:0] wb_pending_mask;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int wr_snap;
   logic [31:0] rf [16];

   always #5 clk = ~clk;

   w0rm_core_reg_write_arbiter #(
      .DATA_WIDTH    (32),
      .NUM_REGISTERS (16)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .alu_wb_valid      (alu_wb_valid),
      .alu_wb_addr       (alu_wb_addr),
      .alu_wb_data       (alu_wb_data),
      .alu_wb_ready      (alu_wb_ready),
      .mem_wb_valid      (mem_wb_valid),
      .mem_wb_addr       (mem_wb_addr),
      .mem_wb_data       (mem_wb_data),
      .mem_wb_ready      (mem_wb_ready),
      .port_write_enable (port_write_enable),
      .port_write_addr   (port_write_addr),
      .port_write_data   (port_write_data),
      .wb_pending_mask   (wb_pending_mask)
   );

   // Register-file stand-in: records what the write port commits
   always @(posedge clk) begin
      if (port_write_enable) begin
         rf[port_write_addr] <= port_write_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [3:0] a, input logic [31:0] d);
      alu_wb_valid = v;
      alu_wb_addr  = a;
      alu_wb_data  = d;
   endtask

   task automatic set_mem(input logic v, input logic [3:0] a, input logic [31:0] d);
      mem_wb_valid = v;
      mem_wb_addr  = a;
      mem_wb_data  = d;
   endtask

   initial begin
      reset_n = 1'b0;
      set_alu(1'b0, 4'd0, 32'h0);
      set_mem(1'b0, 4'd0, 32'h0);
      #2;
      check("rst_we",      64'(port_write_enable), 64'd0);
      check("rst_addr",    64'(port_write_addr),   64'd0);
      check("rst_data",    64'(port_write_data),   64'd0);
      check("rst_mask",    64'(wb_pending_mask),   64'd0);
      check("rst_alu_rdy", 64'(alu_wb_ready),      64'd1);
      check("rst_mem_rdy", 64'(mem_wb_ready),      64'd1);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Lone ALU write r3 = 0x11
      set_alu(1'b1, 4'd3, 32'h11);
      check("t1_alu_rdy", 64'(alu_wb_ready), 64'd1);
      tick();
      set_alu(1'b0, 4'd0, 32'h0);
      check("t1_we_early", 64'(port_write_enable), 64'd0);
      check("t1_mask_slot", 64'(wb_pending_mask), 64'h0008);
      tick();
      check("t1_we",       64'(port_write_enable), 64'd1);
      check("t1_addr",     64'(port_write_addr),   64'd3);
      check("t1_data",     64'(port_write_data),   64'h11);
      check("t1_mask_out", 64'(wb_pending_mask),   64'h0008);
      tick();
      check("t1_we_done",   64'(port_write_enable), 64'd0);
      check("t1_mask_done", 64'(wb_pending_mask),   64'd0);
      check("t1_addr_hold", 64'(port_write_addr),   64'd3);
      check("t1_rf3",       64'(rf[3]),             64'h11);

      // First equal-age tie: memory wins in both builds
      set_alu(1'b1, 4'd1, 32'hA);
      set_mem(1'b1, 4'd2, 32'hB);
      tick();
      set_alu(1'b0, 4'd0, 32'h0);
      set_mem(1'b0, 4'd0, 32'h0);
      check("t2_alu_rdy", 64'(alu_wb_ready),    64'd0);
      check("t2_mem_rdy", 64'(mem_wb_ready),    64'd1);
      check("t2_mask",    64'(wb_pending_mask), 64'h0006);
      tick();
      check("t2_we1",      64'(port_write_enable), 64'd1);
      check("t2_addr1",    64'(port_write_addr),   64'd2);
      check("t2_data1",    64'(port_write_data),   64'hB);
      check("t2_alu_rdy2", 64'(alu_wb_ready),      64'd1);
      tick();
      check("t2_we2",   64'(port_write_enable), 64'd1);
      check("t2_addr2", 64'(port_write_addr),   64'd1);
      check("t2_data2", 64'(port_write_data),   64'hA);
      tick();
      check("t2_idle", 64'(port_write_enable), 64'd0);

      // Second tie: round-robin hands it to the ALU, fixed priority keeps memory
      set_alu(1'b1, 4'd1, 32'hC);
      set_mem(1'b1, 4'd2, 32'hD);
      tick();
      set_alu(1'b0, 4'd0, 32'h0);
      set_mem(1'b0, 4'd0, 32'h0);
      check("t3_alu_rdy", 64'(alu_wb_ready), RR ? 64'd1 : 64'd0);
      check("t3_mem_rdy", 64'(mem_wb_ready), RR ? 64'd0 : 64'd1);
      tick();
      check("t3_addr1", 64'(port_write_addr), RR ? 64'd1  : 64'd2);
      check("t3_data1", 64'(port_write_data), RR ? 64'hC : 64'hD);
      tick();
      check("t3_addr2", 64'(port_write_addr), RR ? 64'd2  : 64'd1);
      check("t3_data2", 64'(port_write_data), RR ? 64'hD : 64'hC);
      tick();
      check("t3_idle", 64'(port_write_enable), 64'd0);

      // Both sources keep offering: after the tie the older entry always wins
      set_alu(1'b1, 4'd1, 32'h21);
      set_mem(1'b1, 4'd2, 32'h22);
      tick();
      check("t4_mem_rdy0", 64'(mem_wb_ready), 64'd1);
      check("t4_alu_rdy0", 64'(alu_wb_ready), 64'd0);
      set_mem(1'b1, 4'd6, 32'h26);
      tick();
      check("t4_addr_a", 64'(port_write_addr), 64'd2);
      check("t4_alu_rdy1", 64'(alu_wb_ready),  64'd1);
      check("t4_mem_rdy1", 64'(mem_wb_ready),  64'd0);
      set_alu(1'b1, 4'd7, 32'h27);
      set_mem(1'b0, 4'd0, 32'h0);
      tick();
      check("t4_addr_b", 64'(port_write_addr), 64'd1);
      check("t4_data_b", 64'(port_write_data), 64'h21);
      check("t4_mem_rdy2", 64'(mem_wb_ready),  64'd1);
      check("t4_alu_rdy2", 64'(alu_wb_ready),  64'd0);
      set_alu(1'b0, 4'd0, 32'h0);
      tick();
      check("t4_addr_c", 64'(port_write_addr), 64'd6);
      check("t4_data_c", 64'(port_write_data), 64'h26);
      tick();
      check("t4_addr_d", 64'(port_write_addr), 64'd7);
      check("t4_data_d", 64'(port_write_data), 64'h27);
      tick();
      check("t4_idle", 64'(port_write_enable), 64'd0);

      // Same destination from both sources: load first, ALU value lands last
      set_mem(1'b1, 4'd5, 32'h1);
      tick();
      set_mem(1'b0, 4'd0, 32'h0);
      set_alu(1'b1, 4'd5, 32'h2);
      check("t5_mask", 64'(wb_pending_mask), 64'h0020);
      tick();
      set_alu(1'b0, 4'd0, 32'h0);
      check("t5_addr1", 64'(port_write_addr), 64'd5);
      check("t5_data1", 64'(port_write_data), 64'h1);
      tick();
      check("t5_we2",   64'(port_write_enable), 64'd1);
      check("t5_data2", 64'(port_write_data),   64'h2);
      tick();
      check("t5_rf5", 64'(rf[5]), 64'h2);

      // ALU streams 8 back-to-back writes
      for (int i = 0; i < 8; i++) begin
         set_alu(1'b1, 4'(i), 32'h100 + 32'(i));
         check("t6_rdy", 64'(alu_wb_ready), 64'd1);
         if (i >= 2) begin
            check("t6_we",   64'(port_write_enable), 64'd1);
            check("t6_addr", 64'(port_write_addr),   64'(i - 2));
         end
         tick();
      end
      set_alu(1'b0, 4'd0, 32'h0);
      check("t6_addr6", 64'(port_write_addr), 64'd6);
      tick();
      check("t6_we7",   64'(port_write_enable), 64'd1);
      check("t6_data7", 64'(port_write_data),   64'h107);
      tick();
      check("t6_idle", 64'(port_write_enable), 64'd0);

      // Reset with both slots and the output stage occupied
      set_alu(1'b1, 4'd8, 32'h88);
      set_mem(1'b1, 4'd9, 32'h99);
      tick();
      set_alu(1'b1, 4'd10, 32'hAA);
      set_mem(1'b1, 4'd11, 32'hBB);
      tick();
      set_alu(1'b0, 4'd0, 32'h0);
      set_mem(1'b0, 4'd0, 32'h0);
      check("t7_we_pre",   64'(port_write_enable), 64'd1);
      check("t7_mask_pre", 64'(wb_pending_mask),   RR ? 64'h0700 : 64'h0B00);
      reset_n = 1'b0;
      #1;
      check("t7_we_rst",      64'(port_write_enable), 64'd0);
      check("t7_mask_rst",    64'(wb_pending_mask),   64'd0);
      check("t7_addr_rst",    64'(port_write_addr),   64'd0);
      check("t7_alu_rdy_rst", 64'(alu_wb_ready),      64'd1);
      check("t7_mem_rdy_rst", 64'(mem_wb_ready),      64'd1);
      wr_snap = wr_cnt;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t7_we_post",   64'(port_write_enable), 64'd0);
         check("t7_mask_post", 64'(wb_pending_mask),   64'd0);
      end
      check("t7_no_writes", 64'(wr_cnt), 64'(wr_snap));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
